// File: rtl/fetch_queue_pkg.sv
// Shared constants for fetch/decode queues: entry field layout and default sizes.
// Any wider decode queue reuses the same field order and packed entry width.
package fetch_queue_pkg;

  localparam int FQ_DATA_W     = 32;
  localparam int FQ_DEPTH      = 4;
  localparam int FQ_NUM_FIELDS = 3;
  localparam int FQ_ENTRY_W    = FQ_NUM_FIELDS * FQ_DATA_W;

  // Field slot within a packed entry, counted from the LSB end.
  typedef enum logic [1:0] {
    FQ_FLD_PC4   = 2'd0,
    FQ_FLD_PC    = 2'd1,
    FQ_FLD_INSTR = 2'd2
  } fq_field_e;

  function automatic int fq_entry_w(input int data_w);
    return FQ_NUM_FIELDS * data_w;
  endfunction

  function automatic int fq_field_lsb(input fq_field_e fld, input int data_w);
    return int'(fld) * data_w;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one asynchronous
// read port, no reset (occupancy is tracked outside, so stale data is never shown).
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: valid/ready push, show-ahead pop
// held by STALL, single-cycle FLUSH on mispredict.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_W = FQ_DATA_W,
  parameter int DEPTH  = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] Instr1_IF,
  input  logic [DATA_W-1:0] Instr_PC_IF,
  input  logic [DATA_W-1:0] Instr_PC_Plus4_IF,
  input  logic              STALL,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] Instr1_OUT,
  output logic [DATA_W-1:0] Instr_PC_OUT,
  output logic [DATA_W-1:0] Instr_PC_Plus4,
  output logic [PTR_W:0]    COUNT
);

  localparam int ENTRY_W   = fq_entry_w(DATA_W);
  localparam int INSTR_LSB = fq_field_lsb(FQ_FLD_INSTR, DATA_W);
  localparam int PC_LSB    = fq_field_lsb(FQ_FLD_PC, DATA_W);
  localparam int PC4_LSB   = fq_field_lsb(FQ_FLD_PC4, DATA_W);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic               push, pop, out_valid;
  logic [ENTRY_W-1:0] wdata, head;

  // Ready comes only from registered occupancy, so a pop while full never
  // lets a push through in the same cycle and STALL has no path to IN_READY.
  assign IN_READY  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = out_valid & ~STALL;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata = {Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF};

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (push & ~FLUSH),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Zero-forcing keeps uninitialised storage from ever reaching decode.
  assign OUT_VALID      = out_valid;
  assign Instr1_OUT     = out_valid ? head[INSTR_LSB +: DATA_W] : '0;
  assign Instr_PC_OUT   = out_valid ? head[PC_LSB +: DATA_W]    : '0;
  assign Instr_PC_Plus4 = out_valid ? head[PC4_LSB +: DATA_W]   : '0;
  assign COUNT          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset, hand-computed vector table, flush and async-reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] instr_if, pc_if, pc4_if;
  logic          stall;
  logic          out_valid;
  logic [DW-1:0] instr_out, pc_out, pc4_out;
  logic [PW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [3*DW-1:0] exp_q[$];

  fetch_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK               (clk),
    .RESET             (rst_n),
    .FLUSH             (flush),
    .IN_VALID          (in_valid),
    .IN_READY          (in_ready),
    .Instr1_IF         (instr_if),
    .Instr_PC_IF       (pc_if),
    .Instr_PC_Plus4_IF (pc4_if),
    .STALL             (stall),
    .OUT_VALID         (out_valid),
    .Instr1_OUT        (instr_out),
    .Instr_PC_OUT      (pc_out),
    .Instr_PC_Plus4    (pc4_out),
    .COUNT             (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event trace, one line per event seen at the edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) $display("[%0t] flush", $time);
      else begin
        if (in_valid && in_ready) $display("[%0t] push pc=%08h instr=%08h", $time, pc_if, instr_if);
        if (out_valid && !stall)  $display("[%0t] pop  pc=%08h", $time, pc_out);
        if (out_valid && stall)   $display("[%0t] stall head pc=%08h", $time, pc_out);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1300_0013;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic [DW-1:0] pc);
    in_valid = v;
    stall    = s;
    flush    = f;
    pc_if    = pc;
    pc4_if   = pc + 32'd4;
    instr_if = instr_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs against an explicit expected head PC and occupancy.
  task automatic check_all(input string tag, input int cnt, input logic ov, input logic ir,
                           input logic [DW-1:0] hpc);
    check({tag, ".count"}, DW'(count), DW'(cnt));
    check({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
    check({tag, ".in_ready"}, DW'(in_ready), DW'(ir));
    check({tag, ".pc_out"}, pc_out, ov ? hpc : '0);
    check({tag, ".pc4_out"}, pc4_out, ov ? hpc + 32'd4 : '0);
    check({tag, ".instr_out"}, instr_out, ov ? instr_of(hpc) : '0);
  endtask

  // ---------------- reference model ----------------
  task automatic model_cycle(input logic v, input logic s, input logic f, input logic [DW-1:0] pc);
    bit rdy, vld;
    rdy = (exp_q.size() != DEPTH);
    vld = (exp_q.size() != 0);
    drive(v, s, f, pc);
    step();
    if (f) exp_q.delete();
    else begin
      if (vld && !s) void'(exp_q.pop_front());
      if (v && rdy)  exp_q.push_back({instr_of(pc), pc, pc + 32'd4});
    end
  endtask

  task automatic check_model(input string tag);
    logic [3*DW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, ".count"}, DW'(count), DW'(exp_q.size()));
    check({tag, ".out_valid"}, DW'(out_valid), DW'(exp_q.size() != 0));
    check({tag, ".in_ready"}, DW'(in_ready), DW'(exp_q.size() != DEPTH));
    check({tag, ".instr_out"}, instr_out, h[3*DW-1:2*DW]);
    check({tag, ".pc_out"}, pc_out, h[2*DW-1:DW]);
    check({tag, ".pc4_out"}, pc4_out, h[DW-1:0]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic          s;
    logic [DW-1:0] pc;
    int            cnt;
    logic          ov;
    logic          ir;
    logic [DW-1:0] hpc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // streaming with STALL=0: each entry shows one cycle after push, COUNT stays 1
    vecs[0]  = '{1'b1, 1'b0, 32'h0040_0000, 1, 1'b1, 1'b1, 32'h0040_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0040_0004, 1, 1'b1, 1'b1, 32'h0040_0004};
    vecs[2]  = '{1'b1, 1'b0, 32'h0040_0008, 1, 1'b1, 1'b1, 32'h0040_0008};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0000_0000};
    // fill under stall; 5th push refused while full
    vecs[4]  = '{1'b1, 1'b1, 32'h0040_0000, 1, 1'b1, 1'b1, 32'h0040_0000};
    vecs[5]  = '{1'b1, 1'b1, 32'h0040_0004, 2, 1'b1, 1'b1, 32'h0040_0000};
    vecs[6]  = '{1'b1, 1'b1, 32'h0040_0008, 3, 1'b1, 1'b1, 32'h0040_0000};
    vecs[7]  = '{1'b1, 1'b1, 32'h0040_000C, 4, 1'b1, 1'b0, 32'h0040_0000};
    vecs[8]  = '{1'b1, 1'b1, 32'h0040_0010, 4, 1'b1, 1'b0, 32'h0040_0000};
    // pop while full with push offered: push still refused
    vecs[9]  = '{1'b1, 1'b0, 32'h0040_0010, 3, 1'b1, 1'b1, 32'h0040_0004};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 2, 1'b1, 1'b1, 32'h0040_0008};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b1, 32'h0040_000C};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0000_0000};

    // ---- reset then idle ----
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (2) step();
    check_all("reset", 0, 1'b0, 1'b1, '0);
    rst_n = 1'b1;
    step();
    check_all("idle", 0, 1'b0, 1'b1, '0);

    // ---- table ----
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].s, 1'b0, vecs[i].pc);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir, vecs[i].hpc);
    end

    // ---- flush mid-stream ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0050_0000 + 32'(4 * i));
      step();
    end
    check_all("pre_flush", 3, 1'b1, 1'b1, 32'h0050_0000);
    drive(1'b1, 1'b0, 1'b1, 32'h0060_0000);
    step();
    check_all("flush", 0, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0070_0000);
    step();
    check_all("post_flush_push", 1, 1'b1, 1'b1, 32'h0070_0000);

    // ---- async reset between edges ----
    drive(1'b1, 1'b1, 1'b0, 32'h0070_0004);
    step();
    check_all("pre_areset", 2, 1'b1, 1'b1, 32'h0070_0000);
    drive(1'b0, 1'b1, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check_all("areset_noclk", 0, 1'b0, 1'b1, '0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0080_0000);
    step();
    check_all("after_areset_push", 1, 1'b1, 1'b1, 32'h0080_0000);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("after_areset_pop", 0, 1'b0, 1'b1, '0);

    // ---- wrap-around: occupancy 0..3 repeatedly, model-checked ----
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        model_cycle(1'b1, 1'b1, 1'b0, 32'h0090_0000 + 32'(16 * r + 4 * k));
        check_model("wrap_push");
      end
      for (int k = 0; k < 3; k++) begin
        model_cycle(1'b0, 1'b0, 1'b0, '0);
        check_model("wrap_pop");
      end
    end

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      model_cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 3),
                  $urandom);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
